// File: rtl/k2_core_p_if.sv
`default_nettype none
// ============================================================================
// Module   : k2_core_p_if
// Purpose  : Bundles the k2_core_p control, instruction-fetch and result
//            signals so the core and its environment share one port.
// Signals  : start, stall      - run control into the core
//            imem_addr         - fetch address (PC) out of the core
//            imem_data         - instruction word back from async memory
//            out_data/out_valid- RO value and its one-cycle update pulse
//            halted, carry_flag- status out of the core
// Modports : master - the core side; slave - the environment side
// Revision : 1.0 - initial release
// ============================================================================
interface k2_core_p_if #(
   parameter int DATA_W = 4,
   parameter int PC_W   = 4,
   parameter int IMM_W  = 3
);
   logic                start;
   logic                stall;
   logic [PC_W-1:0]     imem_addr;
   logic [IMM_W+4:0]    imem_data;
   logic [DATA_W-1:0]   out_data;
   logic                out_valid;
   logic                halted;
   logic                carry_flag;

   modport master (
      input  start, stall, imem_data,
      output imem_addr, out_data, out_valid, halted, carry_flag
   );

   modport slave (
      output start, stall, imem_data,
      input  imem_addr, out_data, out_valid, halted, carry_flag
   );
endinterface
`default_nettype wire

// File: rtl/k2_core_p.sv
`default_nettype none
// ============================================================================
// Module   : k2_core_p
// Purpose  : Tiny accumulator-style core: three data registers (RA, RB, RO),
//            a carry flag, unconditional/conditional jumps and HALT. One
//            instruction per cycle from an asynchronous instruction memory.
// Ports    : clk   - single clock, rising-edge
//            reset - synchronous, active-high
//            bus   - k2_core_p_if.master (start, stall, imem_addr,
//                    imem_data, out_data, out_valid, halted, carry_flag)
// Encoding : MSB first  J, C, D[1:0], S, imm[IMM_W-1:0]
// Revision : 1.0 - initial release
// ============================================================================
module k2_core_p #(
   parameter int DATA_W = 4,
   parameter int PC_W   = 4,
   parameter int IMM_W  = 3
) (
   input  wire             clk,
   input  wire             reset,
   k2_core_p_if.master     bus
);
   localparam int INST_W = IMM_W + 5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [DATA_W-1:0]   ra_q, ra_d;
   logic [DATA_W-1:0]   rb_q, rb_d;
   logic [DATA_W-1:0]   ro_q, ro_d;
   logic                carry_q, carry_d;
   logic                out_valid_q, out_valid_d;

   // Instruction field decode
   logic                inst_j;
   logic                inst_c;
   logic [1:0]          inst_dst;
   logic                inst_s;
   logic [IMM_W-1:0]    inst_imm;

   assign inst_j   = bus.imem_data[INST_W-1];
   assign inst_c   = bus.imem_data[INST_W-2];
   assign inst_dst = bus.imem_data[INST_W-3 -: 2];
   assign inst_s   = bus.imem_data[IMM_W];
   assign inst_imm = bus.imem_data[IMM_W-1:0];

   // ALU: imm[0] selects subtract, done as RA + ~RB + 1 so the carry out
   // reads as "no borrow" for subtraction.
   logic [DATA_W-1:0]   alu_b;
   logic [DATA_W:0]     alu_sum;
   logic [DATA_W-1:0]   imm_data;
   logic [PC_W-1:0]     imm_pc;
   logic [PC_W-1:0]     pc_inc;
   logic [DATA_W-1:0]   wr_val;

   assign alu_b    = inst_imm[0] ? ~rb_q : rb_q;
   assign alu_sum  = {1'b0, ra_q} + {1'b0, alu_b} + {{DATA_W{1'b0}}, inst_imm[0]};
   assign imm_data = DATA_W'(inst_imm);
   assign imm_pc   = PC_W'(inst_imm);
   assign pc_inc   = pc_q + PC_W'(1);
   assign wr_val   = inst_s ? imm_data : alu_sum[DATA_W-1:0];

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ra_d        = ra_q;
      rb_d        = rb_q;
      ro_d        = ro_q;
      carry_d     = carry_q;
      out_valid_d = 1'b0;

      case (state_q)
         ST_IDLE, ST_HALTED: begin
            if (bus.start) begin
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            if (!bus.stall) begin
               pc_d = pc_inc;
               if (inst_j && inst_c) begin
                  // HALT wins over a simultaneous start: start is not
                  // looked at while in RUN.
                  state_d = ST_HALTED;
               end else if (inst_j) begin
                  pc_d = imm_pc;
               end else if (inst_c) begin
                  if (carry_q) begin
                     pc_d = imm_pc;
                  end
               end else begin
                  case (inst_dst)
                     2'b00: ra_d = wr_val;
                     2'b01: rb_d = wr_val;
                     2'b10: begin
                        ro_d        = ra_q;
                        out_valid_d = 1'b1;
                     end
                     default: ;
                  endcase
                  // RO moves never touch the flag; D=11 with S=0 is the
                  // compare form that only updates it.
                  if (!inst_s && (inst_dst != 2'b10)) begin
                     carry_d = alu_sum[DATA_W];
                  end
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         pc_q        <= '0;
         ra_q        <= '0;
         rb_q        <= '0;
         ro_q        <= '0;
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ra_q        <= ra_d;
         rb_q        <= rb_d;
         ro_q        <= ro_d;
         carry_q     <= carry_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.imem_addr  = pc_q;
   assign bus.out_data   = ro_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.halted     = (state_q == ST_HALTED);
   assign bus.carry_flag = carry_q;

endmodule
`default_nettype wire
